poly_coeff4x_packer: RTL and testbench

- Write-side counterpart of the polynomial multiplier's 64-bit packed-coefficient read port.
- Accepts 4 coefficients per beat, on 16-bit lanes with the low COEFF_W bits valid.
- Packs them LSB-first into a continuous bit stream and emits 64-bit words with relative BRAM addresses.
- Output layout is exactly the layout the multiplier reads back on its BRAM read port (256 x 13 bit = 52 words).

---
 rtl/poly_coeff4x_packer.sv | 164 ++++++++++++++++
 tb/tb_poly_coeff4x_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/poly_coeff4x_packer.sv
// Packs 4 x COEFF_W-bit coefficients per beat LSB-first into 64-bit BRAM words; word written one cycle after the completing accept.
// Optional build macro PACK_LANE_CHECK_EN enables the sticky lane_ovf upper-bit check.
module poly_coeff4x_packer #(
   parameter int COEFF_W   = 13,
   parameter int NUM_BEATS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        coeff_valid,
   input  logic [63:0] coeff4x_in,
   output logic        coeff_ready,
   output logic        bram_we,
   output logic [6:0]  bram_address_relative,
   output logic [63:0] pol_64bit_out,
   output logic        busy,
   output logic        pack_done,
   output logic        lane_ovf
);
   localparam int BEAT_W = 4 * COEFF_W;
   localparam int CNT_W  = $clog2(NUM_BEATS + 1);

   typedef enum logic [1:0] {S_IDLE, S_PACK, S_LAST} state_t;

   state_t             state_q, state_d;
   logic [127:0]       buf_q, buf_d;
   logic [6:0]         fill_q, fill_d;
   logic [CNT_W-1:0]   beat_q, beat_d;
   logic [6:0]         word_q, word_d;
   logic               we_q, we_d;
   logic [6:0]         addr_q, addr_d;
   logic [63:0]        data_q, data_d;
   logic               done_q, done_d;

   logic [BEAT_W-1:0]  beat_bits;
   logic [127:0]       merged;
   logic [7:0]         fill_sum;
   logic               accept;
   logic               start_acc;

   assign accept    = coeff_valid && (state_q == S_PACK);
   assign start_acc = start && (state_q == S_IDLE);

   // Upper lane bits are discarded here, so the packed stream never sees them.
   always_comb begin
      beat_bits = '0;
      for (int k = 0; k < 4; k++) begin
         beat_bits[k*COEFF_W +: COEFF_W] = coeff4x_in[16*k +: COEFF_W];
      end
   end

   assign merged   = buf_q | ({{(128-BEAT_W){1'b0}}, beat_bits} << fill_q);
   assign fill_sum = {1'b0, fill_q} + 8'(BEAT_W);

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      fill_d  = fill_q;
      beat_d  = beat_q;
      word_d  = word_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_PACK;
               buf_d   = '0;
               fill_d  = '0;
               beat_d  = '0;
               word_d  = '0;
            end
         end
         S_PACK: begin
            if (accept) begin
               beat_d = beat_q + CNT_W'(1);
               if (fill_sum >= 8'd64) begin
                  we_d   = 1'b1;
                  data_d = merged[63:0];
                  addr_d = word_q;
                  word_d = word_q + 7'd1;
                  buf_d  = merged >> 64;
                  fill_d = fill_sum[6:0] - 7'd64;
               end else begin
                  buf_d  = merged;
                  fill_d = fill_sum[6:0];
               end
               // Total bit count is a multiple of 64, so the last beat always completes a word.
               if (beat_q == CNT_W'(NUM_BEATS - 1)) begin
                  state_d = S_LAST;
                  done_d  = 1'b1;
               end
            end
         end
         S_LAST:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         buf_q   <= '0;
         fill_q  <= '0;
         beat_q  <= '0;
         word_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
         beat_q  <= beat_d;
         word_q  <= word_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign coeff_ready           = (state_q == S_PACK);
   assign busy                  = (state_q != S_IDLE);
   assign bram_we               = we_q;
   assign bram_address_relative = addr_q;
   assign pol_64bit_out         = data_q;
   assign pack_done             = done_q;

`ifdef PACK_LANE_CHECK_EN
   localparam logic [15:0] LANE_MASK = 16'((32'd1 << COEFF_W) - 32'd1);

   logic lane_hi;
   logic ovf_q, ovf_d;

   always_comb begin
      lane_hi = 1'b0;
      for (int k = 0; k < 4; k++) begin
         lane_hi = lane_hi | (|(coeff4x_in[16*k +: 16] & ~LANE_MASK));
      end
      ovf_d = ovf_q;
      if (start_acc) begin
         ovf_d = 1'b0;
      end else if (accept && lane_hi) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign lane_ovf = ovf_q;
`else
   assign lane_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_poly_coeff4x_packer.sv
// Scoreboard bench for poly_coeff4x_packer at default parameters (13-bit lanes, 64 beats, 52 words).
module tb_poly_coeff4x_packer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        coeff_valid = 1'b0;
   logic [63:0] coeff4x_in = '0;
   logic        coeff_ready, bram_we, busy, pack_done, lane_ovf;
   logic [6:0]  bram_address_relative;
   logic [63:0] pol_64bit_out;

   poly_coeff4x_packer dut (
      .clk(clk), .rst(rst), .start(start), .coeff_valid(coeff_valid),
      .coeff4x_in(coeff4x_in), .coeff_ready(coeff_ready), .bram_we(bram_we),
      .bram_address_relative(bram_address_relative), .pol_64bit_out(pol_64bit_out),
      .busy(busy), .pack_done(pack_done), .lane_ovf(lane_ovf)
   );

   always #5 clk = ~clk;

`ifdef PACK_LANE_CHECK_EN
   localparam logic EXP_OVF = 1'b1;
`else
   localparam logic EXP_OVF = 1'b0;
`endif

   typedef struct packed {
      logic [6:0]  addr;
      logic [63:0] data;
      logic        done;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   bit          chk_busy_next = 0;
   logic [15:0] coef[256];
   int          gap[64];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   task automatic fail_note(input string name);
      n_checks++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // Monitor: every write is popped against the scoreboard.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (chk_busy_next) begin
            check("busy_after_done", busy, 0);
            chk_busy_next = 0;
         end
         if (bram_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               fail_note("unexpected_write");
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", bram_address_relative, e.addr);
               check("wr_data", pol_64bit_out, e.data);
               check("wr_done", pack_done, e.done);
            end
            if (pack_done) begin
               done_cnt++;
               chk_busy_next = 1;
            end
         end else if (pack_done) begin
            check("stray_done", pack_done, 0);
         end
      end
   end

   // Reference: lay every coefficient into one flat bit stream, then cut 64-bit words.
   task automatic push_model();
      logic [3327:0] s;
      s = '0;
      for (int i = 0; i < 256; i++) s[i*13 +: 13] = coef[i][12:0];
      for (int w = 0; w < 52; w++)
         exp_q.push_back('{addr: 7'(w), data: s[w*64 +: 64], done: (w == 51)});
   endtask

   task automatic send_beat(input logic [63:0] d, input int g);
      int n;
      coeff_valid = 1'b0;
      repeat (g) @(negedge clk);
      coeff_valid = 1'b1;
      coeff4x_in  = d;
      n = 0;
      while (!coeff_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!coeff_ready) fail_note("ready_timeout");
      @(negedge clk);
      coeff_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) fail_note("idle_timeout");
      repeat (3) @(negedge clk);
   endtask

   task automatic run_poly(input bit ovf_test, input bit storm);
      int w0, d0;
      w0 = wr_cnt;
      d0 = done_cnt;
      pulse_start();
      for (int b = 0; b < 64; b++) begin
         if (storm && b == 20) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         send_beat({coef[4*b+3], coef[4*b+2], coef[4*b+1], coef[4*b]}, gap[b]);
         if (b == 0) check("no_write_after_beat0", bram_we, 0);
         if (b == 1) begin
            check("first_write_we", bram_we, 1);
            check("first_write_addr", bram_address_relative, 0);
         end
         if (ovf_test && b == 4) check("ovf_before", lane_ovf, 0);
         if (ovf_test && b == 5) check("ovf_after", lane_ovf, EXP_OVF);
      end
      if (storm) begin
         check("last_ready", coeff_ready, 0);
         check("last_busy", busy, 1);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_idle();
      check("no_restart", busy, 0);
      check("write_count", 64'(wr_cnt - w0), 52);
      check("done_count", 64'(done_cnt - d0), 1);
      check("queue_empty", 64'(exp_q.size()), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int w0;
      repeat (3) @(negedge clk);
      check("rst_we", bram_we, 0);
      check("rst_addr", bram_address_relative, 0);
      check("rst_data", pol_64bit_out, 0);
      check("rst_done", pack_done, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", coeff_ready, 0);
      check("rst_ovf", lane_ovf, 0);
      rst = 1'b0;
      @(negedge clk);
      coeff_valid = 1'b1;
      @(negedge clk);
      check("idle_valid_ignored", busy, 0);
      coeff_valid = 1'b0;

      // All-zero polynomial, continuous valid.
      for (int i = 0; i < 256; i++) coef[i] = '0;
      for (int b = 0; b < 64; b++) gap[b] = 0;
      for (int w = 0; w < 52; w++) exp_q.push_back('{addr: 7'(w), data: 64'd0, done: (w == 51)});
      run_poly(0, 0);

      // Hand-computed: 1,2,3,4 then all 0x1FFF.
      for (int i = 0; i < 256; i++) coef[i] = 16'h1FFF;
      coef[0] = 16'd1; coef[1] = 16'd2; coef[2] = 16'd3; coef[3] = 16'd4;
      exp_q.push_back('{addr: 7'd0, data: 64'hFFF0_0200_0C00_4001, done: 1'b0});
      for (int w = 1; w < 52; w++) exp_q.push_back('{addr: 7'(w), data: '1, done: (w == 51)});
      run_poly(0, 0);

      // Random coefficients (upper bits included) with ~30% idle gaps.
      for (int i = 0; i < 256; i++) coef[i] = 16'($urandom);
      for (int b = 0; b < 64; b++) gap[b] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : 0;
      push_model();
      run_poly(0, 0);

      // Start pulses while busy and in the LAST cycle.
      push_model();
      run_poly(0, 1);

      // Abort after 10 beats: 520 bits -> 8 words written before reset.
      for (int i = 0; i < 256; i++) coef[i] = '0;
      for (int b = 0; b < 64; b++) gap[b] = 0;
      for (int w = 0; w < 8; w++) exp_q.push_back('{addr: 7'(w), data: 64'd0, done: 1'b0});
      w0 = wr_cnt;
      pulse_start();
      for (int b = 0; b < 10; b++) send_beat(64'd0, 0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_we", bram_we, 0);
      check("abort_addr", bram_address_relative, 0);
      check("abort_data", pol_64bit_out, 0);
      check("abort_busy", busy, 0);
      check("abort_ready", coeff_ready, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_writes", 64'(wr_cnt - w0), 8);
      check("abort_queue", 64'(exp_q.size()), 0);
      for (int w = 0; w < 52; w++) exp_q.push_back('{addr: 7'(w), data: 64'd0, done: (w == 51)});
      run_poly(0, 0);

      // Lane overflow: beat 5 lane 2 carries upper bits, only bit 0 is packed.
      for (int i = 0; i < 256; i++) coef[i] = 16'($urandom_range(0, 16'h1FFF));
      coef[22] = 16'hE001;
      push_model();
      run_poly(1, 0);
      check("ovf_sticky", lane_ovf, EXP_OVF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
